sobel_mag_pipe: RTL and testbench

//  Multi-lane, pipelined gradient-magnitude unit sitting after the Sobel X/Y

---
 rtl/sobel_mag_pipe.sv | 185 ++++++++++++++++++
 tb/tb_sobel_mag_pipe.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_mag_pipe.sv
// sobel_mag_pipe
//   Multi-lane gradient-magnitude stage placed between the Sobel X/Y filters
//   and edge thinning. For each lane it forms either gx^2+gy^2 (L2) or
//   |gx|+|gy| (L1), compares the result against a threshold, normalises it by
//   a right shift and saturates it to OW bits. The block also tracks the frame
//   pixel address. Both sides use valid/ready with full backpressure.
//
// Ports
//   clk, reset        clock and synchronous active-high reset
//   start_i           frame start pulse; honoured only while idle
//   cfg_mode_i        0 = L2, 1 = L1; captured when start is accepted
//   cfg_thresh_i      pre-shift magnitude threshold; captured on start
//   in_valid_i/in_ready_o, in_gx_i/in_gy_i
//                     signed gradient beat, lane 0 in the LSBs
//   out_valid_o/out_ready_i, out_mag_o/out_edge_o/out_addr_o
//                     result beat; out_addr_o is the address of lane 0
//   busy_o            high while a frame is running or draining
//   frame_done_o      one-cycle pulse after the last beat has left
module sobel_mag_pipe #(
   parameter int GW         = 9,
   parameter int OW         = 8,
   parameter int LANES      = 2,
   parameter int CNTW       = 24,
   parameter int START_ADDR = 770,
   parameter int END_ADDR   = 523518,
   parameter int L2_SHIFT   = 9,
   parameter int L1_SHIFT   = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start_i,
   input  logic                  cfg_mode_i,
   input  logic [2*GW-1:0]       cfg_thresh_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [LANES*GW-1:0]   in_gx_i,
   input  logic [LANES*GW-1:0]   in_gy_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [LANES*OW-1:0]   out_mag_o,
   output logic [LANES-1:0]      out_edge_o,
   output logic [CNTW-1:0]       out_addr_o,
   output logic                  busy_o,
   output logic                  frame_done_o
);
   localparam int TW = 2 * GW;
   // One extra bit so that addr+LANES never wraps in the end-of-window compare.
   localparam logic [CNTW:0]   END_W   = (CNTW + 1)'(END_ADDR);
   localparam logic [TW-1:0]   SAT_MAX = TW'(2 ** OW - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

   state_t                    state_q, state_d;
   logic                      frame_done_q;
   logic                      mode_q;
   logic [TW-1:0]             thresh_q;
   logic [CNTW-1:0]           addr_q;

   logic                      s1_valid_q;
   logic [LANES-1:0][TW-1:0]  s1_term_q;
   logic [LANES-1:0]          s1_lane_ok_q;
   logic [CNTW-1:0]           s1_addr_q;
   logic                      s1_last_q;

   logic                      out_valid_q;
   logic [LANES-1:0][OW-1:0]  out_mag_q;
   logic [LANES-1:0]          out_edge_q;
   logic [CNTW-1:0]           out_addr_q;
   logic                      out_last_q;

   logic                      en;
   logic                      accept;
   logic                      last_beat;
   logic                      last_out;
   logic [LANES-1:0][TW-1:0]  term_d;
   logic [LANES-1:0]          lane_ok_d;
   logic [LANES-1:0][OW-1:0]  mag_d;
   logic [LANES-1:0]          edge_d;

   // The whole pipe advances together; the output register frees up either
   // when it is empty or when downstream takes its beat this cycle.
   assign en         = !out_valid_q || out_ready_i;
   assign in_ready_o = (state_q == ST_RUN) && en;
   assign accept     = in_valid_i && in_ready_o;
   assign last_beat  = ({1'b0, addr_q} + (CNTW + 1)'(LANES)) > END_W;
   assign last_out   = out_valid_q && out_ready_i && out_last_q;

   // ---------------- control FSM ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         frame_done_q <= (state_q == ST_DRAIN) && last_out;
      end
   end

   always_comb begin
      state_d = state_q;
      busy_o  = (state_q != ST_IDLE);
      unique case (state_q)
         ST_IDLE:  if (start_i)               state_d = ST_RUN;
         ST_RUN:   if (accept && last_beat)   state_d = ST_DRAIN;
         ST_DRAIN: if (last_out)              state_d = ST_IDLE;
         default:                             state_d = ST_IDLE;
      endcase
   end

   // ---------------- frame configuration and address ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         mode_q   <= 1'b0;
         thresh_q <= '0;
         addr_q   <= CNTW'(START_ADDR);
      end else if (state_q == ST_IDLE && start_i) begin
         mode_q   <= cfg_mode_i;
         thresh_q <= cfg_thresh_i;
         addr_q   <= CNTW'(START_ADDR);
      end else if (accept) begin
         addr_q   <= addr_q + CNTW'(LANES);
      end
   end

   // ---------------- per-lane datapath ----------------
   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic signed [TW-1:0] gx_w, gy_w;
      logic [TW-1:0]        sq, ax, ay, shifted;

      // Widen before squaring/negating so that -2^(GW-1) is handled exactly.
      assign gx_w = {{(TW - GW){in_gx_i[gi*GW + GW - 1]}}, in_gx_i[gi*GW +: GW]};
      assign gy_w = {{(TW - GW){in_gy_i[gi*GW + GW - 1]}}, in_gy_i[gi*GW +: GW]};
      assign sq   = $unsigned(gx_w * gx_w) + $unsigned(gy_w * gy_w);
      assign ax   = gx_w[TW-1] ? $unsigned(-gx_w) : $unsigned(gx_w);
      assign ay   = gy_w[TW-1] ? $unsigned(-gy_w) : $unsigned(gy_w);

      assign term_d[gi]    = mode_q ? (ax + ay) : sq;
      // Lanes beyond the window end are still computed but blanked in S2.
      assign lane_ok_d[gi] = ({1'b0, addr_q} + (CNTW + 1)'(gi)) <= END_W;

      assign shifted    = mode_q ? (s1_term_q[gi] >> L1_SHIFT)
                                 : (s1_term_q[gi] >> L2_SHIFT);
      assign edge_d[gi] = s1_lane_ok_q[gi] && (s1_term_q[gi] > thresh_q);
      assign mag_d[gi]  = !edge_d[gi]        ? '0 :
                          (shifted > SAT_MAX) ? '1 : shifted[OW-1:0];
   end

   // ---------------- pipeline registers ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_q   <= 1'b0;
         s1_term_q    <= '0;
         s1_lane_ok_q <= '0;
         s1_addr_q    <= '0;
         s1_last_q    <= 1'b0;
         out_valid_q  <= 1'b0;
         out_mag_q    <= '0;
         out_edge_q   <= '0;
         out_addr_q   <= '0;
         out_last_q   <= 1'b0;
      end else if (en) begin
         s1_valid_q <= accept;
         if (accept) begin
            s1_term_q    <= term_d;
            s1_lane_ok_q <= lane_ok_d;
            s1_addr_q    <= addr_q;
            s1_last_q    <= last_beat;
         end
         out_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            out_mag_q  <= mag_d;
            out_edge_q <= edge_d;
            out_addr_q <= s1_addr_q;
            out_last_q <= s1_last_q;
         end
      end
   end

   assign out_valid_o  = out_valid_q;
   assign out_mag_o    = out_mag_q;
   assign out_edge_o   = out_edge_q;
   assign out_addr_o   = out_addr_q;
   assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_sobel_mag_pipe.sv
// tb_sobel_mag_pipe
//   Random and directed frames over a small window (addresses 10..14, three
//   beats per frame) checked against an arithmetic reference model and a
//   queue-based scoreboard.
module tb_sobel_mag_pipe;
   localparam int GW = 9, OW = 8, LANES = 2, CNTW = 24;
   localparam int S_ADDR = 10, E_ADDR = 14;

   logic                 clk = 1'b0;
   logic                 reset, start, cfg_mode, in_valid, in_ready;
   logic                 out_valid, out_ready, busy, frame_done;
   logic [2*GW-1:0]      cfg_thresh;
   logic [LANES*GW-1:0]  in_gx, in_gy;
   logic [LANES*OW-1:0]  out_mag;
   logic [LANES-1:0]     out_edge;
   logic [CNTW-1:0]      out_addr;

   always #5 clk = ~clk;

   sobel_mag_pipe #(
      .GW(GW), .OW(OW), .LANES(LANES), .CNTW(CNTW),
      .START_ADDR(S_ADDR), .END_ADDR(E_ADDR), .L2_SHIFT(9), .L1_SHIFT(1)
   ) dut (
      .clk(clk), .reset(reset), .start_i(start), .cfg_mode_i(cfg_mode),
      .cfg_thresh_i(cfg_thresh), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .in_gx_i(in_gx), .in_gy_i(in_gy), .out_valid_o(out_valid),
      .out_ready_i(out_ready), .out_mag_o(out_mag), .out_edge_o(out_edge),
      .out_addr_o(out_addr), .busy_o(busy), .frame_done_o(frame_done)
   );

   int n_checks = 0, n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   typedef struct {
      int          addr;
      logic [15:0] mag;
      logic [1:0]  edge_v;
      bit          last;
      int          cyc;
   } beat_t;

   beat_t       exp_q[$];
   bit          m_busy, m_run, m_done, m_mode;
   int          m_th, m_addr, cyc, last_stall, frame_acc, out_idx;
   bit          hold_prev;
   logic [15:0] hold_mag;
   logic [1:0]  hold_edge;
   logic [23:0] hold_addr;
   logic [15:0] log_mag[8];
   logic [1:0]  log_edge[8];
   int          log_addr[8];

   // Reference for one accepted beat, straight from the arithmetic rules.
   function automatic beat_t model_beat();
      beat_t b;
      b.addr = m_addr; b.last = (m_addr + LANES > E_ADDR); b.cyc = cyc;
      b.mag = '0; b.edge_v = '0;
      for (int l = 0; l < LANES; l++) begin
         int gx, gy, t, mg;
         bit e;
         gx = $signed(in_gx[l*GW +: GW]);
         gy = $signed(in_gy[l*GW +: GW]);
         t  = m_mode ? ((gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy)) : (gx*gx + gy*gy);
         e  = (t > m_th) && (m_addr + l <= E_ADDR);
         mg = t / (m_mode ? 2 : 512);
         if (mg > 255) mg = 255;
         if (!e) mg = 0;
         b.mag[l*8 +: 8] = mg[7:0];
         b.edge_v[l]     = e;
      end
      return b;
   endfunction

   task automatic monitor();
      bit n_busy, n_run, n_done;
      beat_t b;
      n_busy = m_busy; n_run = m_run; n_done = 0;
      cyc++;
      check_eq("frame_done", frame_done, m_done);
      check_eq("busy", busy, m_busy);
      check_eq("in_ready", in_ready, m_run && (!out_valid || out_ready));
      if (hold_prev) begin
         check_eq("hold_valid", out_valid, 1);
         check_eq("hold_mag", out_mag, hold_mag);
         check_eq("hold_edge", out_edge, hold_edge);
         check_eq("hold_addr", out_addr, hold_addr);
      end
      hold_prev = out_valid && !out_ready;
      hold_mag = out_mag; hold_edge = out_edge; hold_addr = out_addr;
      if (hold_prev) last_stall = cyc;
      if (out_valid && out_ready) begin
         check_eq("out_expected", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            b = exp_q.pop_front();
            $display("beat addr=%0d mag=%04h edge=%02b (model addr=%0d mag=%04h edge=%02b)",
                     out_addr, out_mag, out_edge, b.addr, b.mag, b.edge_v);
            check_eq("out_addr", out_addr, b.addr);
            check_eq("out_mag", out_mag, b.mag);
            check_eq("out_edge", out_edge, b.edge_v);
            if (last_stall < b.cyc) check_eq("latency", cyc - b.cyc, 2);
            if (out_idx < 8) begin
               log_mag[out_idx] = out_mag; log_edge[out_idx] = out_edge;
               log_addr[out_idx] = out_addr;
            end
            out_idx++;
            if (b.last) begin n_done = 1; n_busy = 0; end
         end
      end
      if (in_valid && in_ready) begin
         check_eq("accept_in_run", m_run, 1);
         b = model_beat();
         exp_q.push_back(b);
         if (b.last) n_run = 0;
         m_addr += LANES;
         frame_acc++;
      end
      if (start && !m_busy) begin
         n_busy = 1; n_run = 1; m_mode = cfg_mode; m_th = cfg_thresh;
         m_addr = S_ADDR; frame_acc = 0; out_idx = 0;
      end
      m_busy = n_busy; m_run = n_run; m_done = n_done;
   endtask

   task automatic tick();
      #1;
      monitor();
      @(negedge clk);
   endtask

   task automatic gen_data(input int kind);
      for (int l = 0; l < LANES; l++) begin
         int gx, gy;
         if (kind == 1) begin
            gx = -100; gy = 60;
         end else if (kind == 0 && frame_acc == 0) begin
            gx = (l == 0) ? 3 : -256; gy = (l == 0) ? 4 : -256;
         end else if ($urandom_range(0, 1) == 1) begin
            gx = int'($urandom_range(0, 511)) - 256; gy = int'($urandom_range(0, 511)) - 256;
         end else begin
            gx = int'($urandom_range(0, 40)) - 20; gy = int'($urandom_range(0, 40)) - 20;
         end
         in_gx[l*GW +: GW] = gx[GW-1:0];
         in_gy[l*GW +: GW] = gy[GW-1:0];
      end
   endtask

   task automatic check_reset_state();
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_in_ready", in_ready, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_frame_done", frame_done, 0);
      check_eq("rst_out_mag", out_mag, 0);
      check_eq("rst_out_edge", out_edge, 0);
      check_eq("rst_out_addr", out_addr, 0);
   endtask

   task automatic apply_reset();
      reset = 1; start = 0; in_valid = 0; out_ready = 1;
      @(negedge clk);
      reset = 0;
      exp_q.delete();
      m_busy = 0; m_run = 0; m_done = 0; hold_prev = 0;
      check_reset_state();
   endtask

   task automatic run_frame(input int kind, input bit mode, input int th,
                            input bit rnd, input bit poke, input bit stall);
      int guard, fc;
      start = 1; cfg_mode = mode; cfg_thresh = th[17:0]; in_valid = 0; out_ready = 1;
      tick();
      start = 0;
      guard = 0; fc = 0;
      while (m_busy && guard < 300) begin
         guard++;
         gen_data(kind);
         in_valid  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
         if (stall && fc >= 2 && fc <= 6) out_ready = 0;
         if (poke) begin
            start = $urandom_range(0, 1); cfg_mode = $urandom_range(0, 1);
            cfg_thresh = 18'($urandom);
         end
         tick();
         fc++;
      end
      start = 0; in_valid = 0; out_ready = 1;
      check_eq("frame_timeout", guard < 300, 1);
   endtask

   initial begin
      start = 0; cfg_mode = 0; cfg_thresh = '0; in_valid = 0; out_ready = 1;
      in_gx = '0; in_gy = '0;
      cyc = 0; last_stall = -1; frame_acc = 0; out_idx = 0;
      apply_reset();

      // L2 example: {3,4} -> 25 -> mag 0 edge 1; {-256,-256} saturates.
      run_frame(0, 1'b0, 0, 0, 0, 0);
      check_eq("l2_ex_mag", log_mag[0], 16'hFF00);
      check_eq("l2_ex_edge", log_edge[0], 2'b11);
      check_eq("win_addr0", log_addr[0], 10);
      check_eq("win_addr1", log_addr[1], 12);
      check_eq("win_addr2", log_addr[2], 14);
      check_eq("win_lane1_edge", log_edge[2][1], 0);

      // L1 example: |-100|+|60| = 160.
      run_frame(1, 1'b1, 200, 0, 0, 0);
      check_eq("l1_th200_mag", log_mag[0], 0);
      check_eq("l1_th200_edge", log_edge[0], 0);
      run_frame(1, 1'b1, 100, 0, 0, 0);
      check_eq("l1_th100_mag", log_mag[0], 16'h5050);
      check_eq("l1_th100_edge", log_edge[0], 2'b11);
      check_eq("l1_last_mag", log_mag[2], 16'h0050);
      check_eq("l1_last_edge", log_edge[2], 2'b01);

      // Five-cycle downstream stall mid-stream.
      run_frame(2, 1'b0, int'($urandom_range(0, 70000)), 0, 0, 1);

      // start and cfg_mode toggled mid-frame must be ignored.
      run_frame(2, 1'b1, int'($urandom_range(0, 600)), 1, 1, 0);

      // Reset with two beats in flight, then a clean frame.
      start = 1; cfg_mode = 0; cfg_thresh = 18'd100; in_valid = 0; out_ready = 1;
      tick();
      start = 0;
      for (int k = 0; k < 3; k++) begin
         gen_data(2);
         in_valid = (k < 2); out_ready = 0;
         tick();
      end
      apply_reset();
      run_frame(2, 1'b0, int'($urandom_range(0, 70000)), 1, 0, 0);

      for (int f = 0; f < 30; f++) begin
         bit md;
         md = $urandom_range(0, 1);
         run_frame(2, md, md ? int'($urandom_range(0, 600)) : int'($urandom_range(0, 70000)),
                   1, $urandom_range(0, 1), $urandom_range(0, 1));
      end
      tick();
      tick();
      check_eq("queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
